// File: rtl/kernel_issue_ctrl.sv
// Initiator-side issue controller for the non-pipelined compute kernel: one operation in flight,
// measured issue-to-result latency. Optional result timeout enabled by defining KERNEL_TIMEOUT_EN.
module kernel_issue_ctrl #(
  parameter int unsigned LAT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       iData,
  input  logic             iSign,
  input  logic             iValid,
  output logic             oReady,
  output logic [7:0]       oKData,
  output logic             oKSign,
  output logic             oKDataValid,
  input  logic [9:0]       iKData,
  input  logic             iKDataValid,
  output logic [9:0]       oData,
  output logic             oDataValid,
  input  logic             iReady,
  output logic [LAT_W-1:0] oLatency,
  output logic             oErr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int unsigned      LAT_MAX = (1 << LAT_W) - 1;
  localparam logic [LAT_W-1:0] TO_LAT  = (TIMEOUT > LAT_MAX) ? LAT_W'(LAT_MAX) : LAT_W'(TIMEOUT);

  state_t           state, nextState;
  logic [7:0]       opData;
  logic             opSign;
  logic [LAT_W-1:0] latCnt;
  logic [LAT_W-1:0] latInc;
  logic             accept;
  logic             capture;
  logic             timeout;

  assign accept  = iValid && oReady;
  assign capture = (state == WAIT) && iKDataValid;
  assign latInc  = (latCnt == '1) ? latCnt : latCnt + 1'b1;

`ifdef KERNEL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] waitCnt;

  // Separate from latCnt so a narrow LAT_W cannot postpone the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (state == ISSUE) begin
      waitCnt <= '0;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  assign timeout = (state == WAIT) && !iKDataValid && (waitCnt == TO_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (capture || timeout) nextState = RESP;
      RESP:    if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so every output is 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oReady      <= 1'b0;
      oKDataValid <= 1'b0;
      oDataValid  <= 1'b0;
      opData      <= '0;
      opSign      <= 1'b0;
      latCnt      <= '0;
      oData       <= '0;
      oLatency    <= '0;
      oErr        <= 1'b0;
    end else begin
      oReady      <= (nextState == IDLE);
      oKDataValid <= (nextState == ISSUE);
      oDataValid  <= (nextState == RESP);
      if (accept) begin
        opData <= iData;
        opSign <= iSign;
      end
      if (state == ISSUE) begin
        latCnt <= '0;
      end else if (state == WAIT) begin
        latCnt <= latInc;
      end
      if (capture) begin
        oData    <= iKData;
        oLatency <= latInc;
        oErr     <= 1'b0;
      end else if (timeout) begin
        oData    <= '0;
        oLatency <= TO_LAT;
        oErr     <= 1'b1;
      end
    end
  end

  assign oKData = oKDataValid ? opData : '0;
  assign oKSign = oKDataValid && opSign;

endmodule

// File: tb/tb_kernel_issue_ctrl.sv
// Self-checking bench for kernel_issue_ctrl: LAT_W=8 and LAT_W=4 instances share one stimulus
// stream; a behavioural kernel/latency model supplies every expected value.
module tb_kernel_issue_ctrl;

  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] iData = '0;
  logic       iSign = 1'b0;
  logic       iValid = 1'b0;
  logic [9:0] iKData = '0;
  logic       iKDataValid = 1'b0;
  logic       iReady = 1'b0;

  logic       aReady, aKSign, aKValid, aValid, aErr;
  logic [7:0] aKData;
  logic [9:0] aData;
  logic [7:0] aLat;
  logic       bReady, bKSign, bKValid, bValid, bErr;
  logic [7:0] bKData;
  logic [9:0] bData;
  logic [3:0] bLat;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  kernel_issue_ctrl #(.LAT_W(8), .TIMEOUT(TIMEOUT)) uA (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iSign(iSign), .iValid(iValid), .oReady(aReady),
    .oKData(aKData), .oKSign(aKSign), .oKDataValid(aKValid), .iKData(iKData),
    .iKDataValid(iKDataValid), .oData(aData), .oDataValid(aValid), .iReady(iReady),
    .oLatency(aLat), .oErr(aErr)
  );

  kernel_issue_ctrl #(.LAT_W(4), .TIMEOUT(TIMEOUT)) uB (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iSign(iSign), .iValid(iValid), .oReady(bReady),
    .oKData(bKData), .oKSign(bKSign), .oKDataValid(bKValid), .iKData(iKData),
    .iKDataValid(iKDataValid), .oData(bData), .oDataValid(bValid), .iReady(iReady),
    .oLatency(bLat), .oErr(bErr)
  );

  always @(negedge clk) if (aKValid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned satLat(input int unsigned k, input int unsigned w);
    int unsigned mx;
    mx = (1 << w) - 1;
    return (k > mx) ? mx : k;
  endfunction

  task automatic waitReady();
    int n;
    n = 0;
    while (aReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", aReady, 1);
  endtask

  // Offer one operand; the cycle after acceptance must be the single issue pulse.
  task automatic issueOp(input logic [7:0] d, input logic s, input bit junk);
    waitReady();
    iData = d; iSign = s; iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0; iData = 8'($urandom); iSign = 1'($urandom);
    chk("issue_valid", aKValid, 1);
    chk("issue_valid_b", bKValid, 1);
    chk("issue_data", aKData, d);
    chk("issue_sign", aKSign, s);
    chk("issue_busy", aReady, 0);
    if (junk) begin
      iKDataValid = 1'b1; iKData = 10'($urandom);
    end
  endtask

  // Kernel model: answers d on WAIT cycle k (first WAIT cycle is 1).
  task automatic respond(input int unsigned k, input logic [9:0] d);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (j == k) begin
        chk("wait_no_result", aValid, 0);
        iKDataValid = 1'b1; iKData = d;
      end else begin
        iKDataValid = 1'b0;
      end
    end
    @(negedge clk);
    iKDataValid = 1'b0;
  endtask

  task automatic checkResp(input logic [9:0] d, input int unsigned l8, input int unsigned l4,
                           input logic err);
    chk("resp_valid", aValid, 1);
    chk("resp_valid_b", bValid, 1);
    chk("resp_data", aData, d);
    chk("resp_data_b", bData, d);
    chk("resp_lat", aLat, l8);
    chk("resp_lat_b", bLat, l4);
    chk("resp_err", aErr, err);
    chk("resp_err_b", bErr, err);
  endtask

  task automatic consume(input int unsigned bp);
    iReady = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_hold_valid", aValid, 1);
    end
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
    chk("drop_valid", aValid, 0);
    chk("back_idle", aReady, 1);
  endtask

  initial begin
    int p0;
    int n;
    bit sawValid;
    logic [9:0] r;
    logic [9:0] r2;
    int unsigned k;

    #20;
    chk("reset_outs", {aReady, aKValid, aKData, aKSign, aValid, aData, aLat, aErr}, 0);
    chk("reset_outs_b", {bReady, bKValid, bKData, bKSign, bValid, bData, bLat, bErr}, 0);
    #37 rst_n = 1'b1;
    @(negedge clk);

    issueOp(8'd128, 1'b0, 1'b0);
    respond(5, 10'd256);
    checkResp(10'd256, 5, 5, 1'b0);
    consume(0);

    // Second operand held valid while the first is in flight.
    p0 = pulses;
    waitReady();
    iData = 8'd63; iSign = 1'b1; iValid = 1'b1; iReady = 1'b1;
    @(negedge clk);
    chk("b2b_issue1", {aKValid, aKSign, aKData}, {1'b1, 1'b1, 8'd63});
    iData = 8'd5; iSign = 1'b0;
    r = 10'($urandom);
    respond(3, r);
    checkResp(r, 3, 3, 1'b0);
    chk("b2b_busy", aReady, 0);
    @(negedge clk);
    chk("b2b_gap_no_issue", aKValid, 0);
    chk("b2b_gap_ready", aReady, 1);
    @(negedge clk);
    chk("b2b_issue2", {aKValid, aKSign, aKData}, {1'b1, 1'b0, 8'd5});
    iValid = 1'b0;
    r2 = 10'($urandom);
    respond(3, r2);
    checkResp(r2, 3, 3, 1'b0);
    @(negedge clk);
    iReady = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_pulses", pulses - p0, 2);

    // Backpressure with a spurious kernel response and a pending operand.
    issueOp(8'd200, 1'b1, 1'b0);
    respond(4, 10'd300);
    checkResp(10'd300, 4, 4, 1'b0);
    iValid = 1'b1; iData = 8'd77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        iKDataValid = 1'b1; iKData = 10'd7;
      end else begin
        iKDataValid = 1'b0;
      end
      chk("bp_valid", aValid, 1);
      chk("bp_data", aData, 300);
      chk("bp_lat", aLat, 4);
      chk("bp_ready", aReady, 0);
    end
    iKDataValid = 1'b0; iValid = 1'b0;
    consume(0);

    issueOp(8'd17, 1'b0, 1'b0);
    respond(20, 10'd513);
    checkResp(10'd513, 20, 15, 1'b0);
    consume(0);

    issueOp(8'd33, 1'b1, 1'b0);
    respond(TIMEOUT, 10'd1000);
    checkResp(10'd1000, satLat(TIMEOUT, 8), satLat(TIMEOUT, 4), 1'b0);
    consume(0);

`ifdef KERNEL_TIMEOUT_EN
    issueOp(8'd44, 1'b0, 1'b0);
    n = 0;
    while (aValid !== 1'b1 && n < int'(TIMEOUT) + 10) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TIMEOUT + 1);
    checkResp(10'd0, satLat(TIMEOUT, 8), satLat(TIMEOUT, 4), 1'b1);
    iKDataValid = 1'b1; iKData = 10'd123;
    @(negedge clk);
    iKDataValid = 1'b0;
    chk("to_late_data", aData, 0);
    consume(0);
`endif

    for (int t = 0; t < 12; t++) begin
      k = $urandom_range(1, 12);
      r = 10'($urandom);
      issueOp(8'($urandom), 1'($urandom), 1'($urandom));
      respond(k, r);
      checkResp(r, satLat(k, 8), satLat(k, 4), 1'b0);
      consume($urandom_range(0, 3));
    end

    // Asynchronous reset in WAIT, then a late response that must be ignored.
    issueOp(8'd9, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {aReady, aKValid, aKData, aKSign, aValid, aData, aLat, aErr}, 0);
    chk("async_reset_b", {bReady, bKValid, bKData, bKSign, bValid, bData, bLat, bErr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", aReady, 1);
    iKDataValid = 1'b1; iKData = 10'd99;
    @(negedge clk);
    iKDataValid = 1'b0;
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (aValid !== 1'b0 || bValid !== 1'b0) sawValid = 1'b1;
    end
    chk("post_reset_no_result", sawValid, 0);
    chk("post_reset_data", aData, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
